multicycle_main_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS datapath. Sequences fetch, decode, execute, memory
//  and writeback for lw, sw, R-type, beq, bne, j, addi and andi. Drives the 2-bit ALUop consumed
//  by the ALU-control decoder (00 add, 01 sub, 10 funct, 11 and). Stalls on a memory ready

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/mem_wait_timer.sv | 37 +++
 rtl/multicycle_main_ctrl.sv | 156 +++++++++++++++
 tb/tb_multicycle_main_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the multi-cycle MIPS main control
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        RTYPE   = 4'd7,
        ALUWB   = 4'd8,
        ADDI    = 4'd9,
        ANDI    = 4'd10,
        ALUWB_I = 4'd11,
        BRANCH  = 4'd12,
        JUMP    = 4'd13,
        HALT    = 4'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory request open until mem_ready
    function automatic logic is_mem_state(input state_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts stalled memory cycles and flags a timeout at LIMIT
module mem_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic wait_en_i,
    output logic timeout_o
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign timeout_o = wait_en_i && (count_q == LIMIT_C);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (wait_en_i && !timeout_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// rtl/multicycle_main_ctrl.sv - main control FSM for the multi-cycle MIPS datapath
module multicycle_main_ctrl #(
    parameter int STALL_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       fault,
    output logic [3:0] state_dbg
);
    import mips_ctrl_pkg::*;

    state_e state_q;
    state_e state_d;
    logic   fault_q;
    logic   timeout;

    // Any state change restarts the wait count, so each memory state starts from zero
    mem_wait_timer #(.LIMIT(STALL_LIMIT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_d != state_q),
        .wait_en_i (is_mem_state(state_q) && !mem_ready),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (mem_ready) state_d = DECODE; else if (timeout) state_d = HALT;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_RTYPE:       state_d = RTYPE;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:           state_d = JUMP;
                    OP_ADDI:        state_d = ADDI;
                    OP_ANDI:        state_d = ANDI;
                    default:        state_d = HALT;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (mem_ready) state_d = MEMWB; else if (timeout) state_d = HALT;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (mem_ready) state_d = FETCH; else if (timeout) state_d = HALT;
            RTYPE:   state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            ADDI:    state_d = ALUWB_I;
            ANDI:    state_d = ALUWB_I;
            ALUWB_I: state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JUMP:    state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == HALT) fault_q <= 1'b1;
        end
    end

    assign fault     = fault_q;
    assign state_dbg = state_q;

    // Moore decode; only the FETCH loads and the branch PC enable look at live inputs
    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        pc_source  = PCSRC_ALU;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE:  alu_src_b = SRCB_IMM_SH2;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            RTYPE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            ADDI: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ANDI: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_AND;
            end
            ALUWB_I: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_en     = opcode[0] ? ~zero : zero;
            end
            JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_en     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// tb/tb_multicycle_main_ctrl.sv - directed self-checking bench for multicycle_main_ctrl
module tb_multicycle_main_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_RTYPE = 4'd7,
                           S_ALUWB = 4'd8, S_ANDI = 4'd10, S_ALUWB_I = 4'd11,
                           S_BRANCH = 4'd12, S_JUMP = 4'd13, S_HALT = 4'd14;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write;
    logic       alu_src_a, fault;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;
    logic [15:0] ctl;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    multicycle_main_ctrl #(.STALL_LIMIT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .fault      (fault),
        .state_dbg  (state_dbg)
    );

    assign ctl = {pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_source, fault};

    function automatic logic [15:0] mk(input logic pe, input logic iod, input logic mr,
                                       input logic mw, input logic ir, input logic m2r,
                                       input logic rd, input logic rw, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ao,
                                       input logic [1:0] ps, input logic f);
        return {pe, iod, mr, mw, ir, m2r, rd, rw, sa, sb, ao, ps, f};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [15:0] c);
        #1;
        check({tag, "_state"}, {12'd0, state_dbg}, {12'd0, st});
        check({tag, "_ctl"}, ctl, c);
    endtask

    logic [15:0] c_zero, c_fetch_rdy, c_fetch_wait, c_decode, c_rtype, c_aluwb, c_memadr;
    logic [15:0] c_memrd, c_memwb, c_memwr, c_andi, c_aluwb_i, c_jump, c_halt;
    logic [15:0] c_beq_taken, c_bne_not;

    initial begin
        c_zero       = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        c_fetch_rdy  = mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        c_fetch_wait = mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        c_decode     = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        c_rtype      = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        c_aluwb      = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        c_memadr     = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        c_memrd      = mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        c_memwb      = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        c_memwr      = mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        c_andi       = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0);
        c_aluwb_i    = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
        c_jump       = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
        c_beq_taken  = mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        c_bne_not    = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        c_halt       = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1);

        rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) tick();
        chk("reset", S_IDLE, c_zero);
        rst_n = 1'b1;
        chk("idle_after_release", S_IDLE, c_zero);

        // add
        tick(); chk("add_fetch", S_FETCH, c_fetch_rdy);
        tick(); chk("add_decode", S_DECODE, c_decode);
        tick(); chk("add_rtype", S_RTYPE, c_rtype);
        tick(); chk("add_aluwb", S_ALUWB, c_aluwb);

        // lw with three stalled cycles in MEMRD
        opcode = 6'b100011;
        tick(); chk("lw_fetch", S_FETCH, c_fetch_rdy);
        tick(); chk("lw_decode", S_DECODE, c_decode);
        tick(); chk("lw_memadr", S_MEMADR, c_memadr);
        tick(); mem_ready = 1'b0; chk("lw_memrd0", S_MEMRD, c_memrd);
        tick(); chk("lw_memrd1", S_MEMRD, c_memrd);
        tick(); chk("lw_memrd2", S_MEMRD, c_memrd);
        tick(); mem_ready = 1'b1; chk("lw_memrd3", S_MEMRD, c_memrd);
        tick(); chk("lw_memwb", S_MEMWB, c_memwb);

        // beq taken
        opcode = 6'b000100; zero = 1'b1;
        tick(); chk("beq_fetch", S_FETCH, c_fetch_rdy);
        tick(); chk("beq_decode", S_DECODE, c_decode);
        tick(); chk("beq_branch", S_BRANCH, c_beq_taken);

        // bne not taken
        opcode = 6'b000101;
        tick(); chk("bne_fetch", S_FETCH, c_fetch_rdy);
        tick(); chk("bne_decode", S_DECODE, c_decode);
        tick(); chk("bne_branch", S_BRANCH, c_bne_not);
        zero = 1'b0;

        // andi
        opcode = 6'b001100;
        tick(); chk("andi_fetch", S_FETCH, c_fetch_rdy);
        tick(); chk("andi_decode", S_DECODE, c_decode);
        tick(); chk("andi_exec", S_ANDI, c_andi);
        tick(); chk("andi_wb", S_ALUWB_I, c_aluwb_i);

        // sw
        opcode = 6'b101011;
        tick(); chk("sw_fetch", S_FETCH, c_fetch_rdy);
        tick(); chk("sw_decode", S_DECODE, c_decode);
        tick(); chk("sw_memadr", S_MEMADR, c_memadr);
        tick(); chk("sw_memwr", S_MEMWR, c_memwr);

        // illegal opcode
        opcode = 6'b111111;
        tick(); chk("ill_fetch", S_FETCH, c_fetch_rdy);
        tick(); chk("ill_decode", S_DECODE, c_decode);
        tick(); chk("ill_halt0", S_HALT, c_halt);
        mem_ready = 1'b0;
        tick(); chk("ill_halt1", S_HALT, c_halt);
        opcode = 6'b000000; mem_ready = 1'b1;
        tick(); chk("ill_halt2", S_HALT, c_halt);

        // asynchronous reset mid-cycle
        rst_n = 1'b0;
        chk("async_reset", S_IDLE, c_zero);
        tick(); rst_n = 1'b1; mem_ready = 1'b0; opcode = 6'b000010;

        // mem_ready arriving in the limit cycle completes normally
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("fetch_wait_ok", S_FETCH, c_fetch_wait);
            tick();
        end
        mem_ready = 1'b1;
        chk("fetch_limit_ready", S_FETCH, c_fetch_rdy);
        tick(); chk("j_decode", S_DECODE, c_decode);
        tick(); chk("j_jump", S_JUMP, c_jump);

        // timeout in FETCH
        tick(); mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("fetch_timeout_wait", S_FETCH, c_fetch_wait);
            tick();
        end
        chk("timeout_halt", S_HALT, c_halt);
        tick(); chk("timeout_halt_hold", S_HALT, c_halt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
